// File: rtl/fft_consts.sv
// Shared FFT core constants, sample type, loader state encoding and the
// address bit-reversal helper.
package fft_consts;

   localparam int N_LOG2     = 4;
   localparam int N          = 1 << N_LOG2;
   localparam int DW_COMPLEX = 32;

   typedef struct packed {
      logic signed [DW_COMPLEX/2-1:0] r;
      logic signed [DW_COMPLEX/2-1:0] i;
   } complex_t;

   typedef enum logic [1:0] {
      LD_LOAD  = 2'd0,
      LD_FLUSH = 2'd1,
      LD_START = 2'd2,
      LD_WAIT  = 2'd3
   } loader_state_t;

   // Mirror the N_LOG2 address bits: bit 0 becomes the MSB.
   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
      logic [N_LOG2-1:0] r;
      r = '0;
      for (int b = 0; b < N_LOG2; b++) begin
         r[N_LOG2-1-b] = a[b];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_input_loader.sv
// Loads one N-sample frame into RAM A port A, then starts the AGU and waits
// for it. Define FFT_LOADER_BITREV_EN for bit-reversed write order (DIT core).
module fft_input_loader #(
   parameter int N_LOG2     = fft_consts::N_LOG2,
   parameter int DW_COMPLEX = fft_consts::DW_COMPLEX
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DW_COMPLEX-1:0] s_data,
   input  logic                  s_last,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [N_LOG2-1:0]     ram_addr,
   output logic [DW_COMPLEX-1:0] ram_din,
   output logic                  fft_start,
   input  logic                  fft_done,
   output logic                  frame_err
);

   import fft_consts::*;

   localparam logic [N_LOG2-1:0] CNT_LAST = '1;

   loader_state_t     state;
   logic [N_LOG2-1:0] cnt;
   logic [N_LOG2-1:0] wr_addr;
   logic              accept;

   // Ready is forced low while reset is held so no beat is taken mid-reset.
   assign s_ready = rst_n && (state == LD_LOAD);
   assign accept  = s_valid && s_ready;

`ifdef FFT_LOADER_BITREV_EN
   assign wr_addr = bitrev(cnt);
`else
   assign wr_addr = cnt;
`endif

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values; blocking would create order-dependent logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LD_LOAD;
         cnt       <= '0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         fft_start <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         ram_en    <= accept;
         ram_we    <= accept;
         fft_start <= 1'b0;
         frame_err <= 1'b0;

         if (accept) begin
            ram_addr <= wr_addr;
            ram_din  <= s_data;
         end

         case (state)
            LD_LOAD: begin
               if (accept) begin
                  if (cnt == CNT_LAST) begin
                     // Full frame: commit it even if s_last was missing.
                     cnt       <= '0;
                     state     <= LD_FLUSH;
                     frame_err <= !s_last;
                  end else if (s_last) begin
                     // Early last: drop the partial frame and restart.
                     cnt       <= '0;
                     frame_err <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            LD_FLUSH: begin
               state     <= LD_START;
               fft_start <= 1'b1;
            end
            LD_START: state <= LD_WAIT;
            LD_WAIT:  if (fft_done) state <= LD_LOAD;
            default:  state <= LD_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: frame-level model plus directed
// frames covering ordering, gaps, framing errors, hold-off and mid-frame reset.
module tb_fft_input_loader;

   localparam int NL = fft_consts::N_LOG2;
   localparam int NN = 1 << NL;
   localparam int DW = fft_consts::DW_COMPLEX;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          fft_done = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready, ram_en, ram_we, fft_start, frame_err;
   logic [NL-1:0] ram_addr;
   logic [DW-1:0] ram_din;

   fft_input_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .fft_start (fft_start),
      .fft_done  (fft_done),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected RAM address for beat k of a frame.
   function automatic int exp_addr(input int k);
`ifdef FFT_LOADER_BITREV_EN
      int r;
      r = 0;
      for (int b = 0; b < NL; b++) r = r * 2 + ((k >> b) & 1);
      return r;
`else
      return k;
`endif
   endfunction

   // Frame-level model: m_since < 0 means collecting beats, otherwise it counts
   // cycles since the frame's final beat (0 flush, 1 start pulse, 2 waiting).
   int            m_since = -1;
   int            m_k = 0;
   logic          m_we = 1'b0;
   int            m_addr = 0;
   logic [DW-1:0] m_din = '0;
   logic          m_err = 1'b0;
   int            cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_since <= -1;
         m_k     <= 0;
         m_we    <= 1'b0;
         m_addr  <= 0;
         m_din   <= '0;
         m_err   <= 1'b0;
      end else begin
         m_we <= s_valid && (m_since < 0);
         if (s_valid && (m_since < 0)) begin
            m_addr <= exp_addr(m_k);
            m_din  <= s_data;
            m_err  <= (m_k == NN - 1) ? !s_last : s_last;
            m_k    <= (m_k == NN - 1 || s_last) ? 0 : m_k + 1;
            if (m_k == NN - 1) m_since <= 0;
         end else begin
            m_err <= 1'b0;
            if (m_since >= 2 && fft_done) m_since <= -1;
            else if (m_since >= 0 && m_since < 2) m_since <= m_since + 1;
         end
      end
   end

   // Observed-write bookkeeping and the per-cycle comparison against the model.
   logic [DW-1:0] mem_seen [NN];
   logic [NN-1:0] wmask = '0;
   int            n_wr = 0;
   int            n_start = 0;
   int            n_ferr = 0;
   int            start_cyc = 0;
   int            last_acc_cyc = 0;
   bit            checking = 1'b0;

   always @(negedge clk) begin
      if (checking) begin
         check("s_ready",   s_ready,   rst_n && (m_since < 0));
         check("ram_en",    ram_en,    m_we);
         check("ram_we",    ram_we,    m_we);
         check("ram_addr",  ram_addr,  m_addr);
         check("ram_din",   ram_din,   m_din);
         check("fft_start", fft_start, m_since == 1);
         check("frame_err", frame_err, m_err);
         if (ram_we) begin
            mem_seen[ram_addr] <= ram_din;
            wmask[ram_addr]    <= 1'b1;
            n_wr               <= n_wr + 1;
         end
         if (fft_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
         end
         if (frame_err) n_ferr <= n_ferr + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic beat(input logic [DW-1:0] d, input logic last, input bit gaps);
      int budget;
      budget = 0;
      if (gaps) begin
         while ($urandom_range(0, 1) == 1 && budget < 3) begin
            s_valid = 1'b0;
            step();
            budget++;
         end
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      budget  = 0;
      while (m_since >= 0) begin
         step();
         budget++;
         if (budget > 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: beat %0h never accepted", d);
            s_valid = 1'b0;
            return;
         end
      end
      step();
      last_acc_cyc = cyc;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int base, input int n, input int last_idx, input bit gaps);
      for (int k = 0; k < n; k++) beat(DW'(base + k), k == last_idx, gaps);
   endtask

   task automatic release_agu();
      repeat (4) step();
      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
   endtask

   task automatic clear_marks();
      wmask = '0;
      n_wr  = 0;
   endtask

   int start0, err0;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      checking = 1'b1;
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_ram_addr", ram_addr, 0);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", s_ready, 1);

      // Natural frame: data k on beat k, last on beat 15.
      clear_marks();
      start0 = n_start;
      err0   = n_ferr;
      send_frame(0, NN, NN - 1, 1'b0);
      repeat (2) step();
`ifdef FFT_LOADER_BITREV_EN
      check("beat1_addr8",   mem_seen[8],  1);
      check("beat3_addr12",  mem_seen[12], 3);
      check("beat2_addr4",   mem_seen[4],  2);
`else
      check("beat1_addr1",   mem_seen[1],  1);
      check("beat3_addr3",   mem_seen[3],  3);
      check("beat2_addr2",   mem_seen[2],  2);
`endif
      check("beat15_addr15", mem_seen[15], 15);
      check("beat0_addr0",   mem_seen[0],  0);
      check("f1_writes",     n_wr, NN);
      check("f1_start_cnt",  n_start - start0, 1);
      check("f1_start_lat",  start_cyc - last_acc_cyc, 1);
      check("f1_no_err",     n_ferr - err0, 0);

      // Valid held high while waiting for the AGU: no writes, no ready.
      s_valid = 1'b1;
      s_data  = 32'hDEAD_BEEF;
      repeat (5) step();
      check("wait_ready", s_ready, 0);
      check("wait_writes", n_wr, NN);
      fft_done = 1'b1;
      s_valid  = 1'b0;
      step();
      fft_done = 1'b0;
      @(negedge clk);
      check("ready_after_done", s_ready, 1);

      // Random gaps in s_valid.
      clear_marks();
      err0 = n_ferr;
      send_frame('h100, NN, NN - 1, 1'b1);
      repeat (2) step();
      check("gap_writes", n_wr, NN);
      check("gap_distinct", wmask, {NN{1'b1}});
      check("gap_no_err", n_ferr - err0, 0);
      release_agu();

      // Early last on beat 5, then a clean frame.
      clear_marks();
      start0 = n_start;
      err0   = n_ferr;
      send_frame('h200, 6, 5, 1'b0);
      repeat (3) step();
      check("early_err", n_ferr - err0, 1);
      check("early_no_start", n_start - start0, 0);
      check("early_writes", n_wr, 6);
      send_frame('h300, NN, NN - 1, 1'b0);
      repeat (2) step();
      check("refill_addr0", mem_seen[0], 'h300);
      check("refill_start", n_start - start0, 1);
      release_agu();

      // Full frame without s_last: error pulse, still started.
      start0 = n_start;
      err0   = n_ferr;
      send_frame('h400, NN, -1, 1'b0);
      repeat (3) step();
      check("nolast_err", n_ferr - err0, 1);
      check("nolast_start", n_start - start0, 1);
      release_agu();

      // Reset after beat 7, then a fresh frame.
      send_frame('h500, 8, -1, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_en", ram_en, 0);
      check("midrst_addr", ram_addr, 0);
      check("midrst_din", ram_din, 0);
      check("midrst_ready", s_ready, 0);
      repeat (2) step();
      rst_n = 1'b1;
      start0 = n_start;
      err0   = n_ferr;
      send_frame('h600, NN, NN - 1, 1'b0);
      repeat (2) step();
      check("postrst_addr0", mem_seen[0], 'h600);
      check("postrst_start", n_start - start0, 1);
      check("postrst_no_err", n_ferr - err0, 0);
      release_agu();
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
